alex_cc_decoder: RTL and testbench
==================================

ALEX_CC_DECODER -- requirements
Module: alex_cc_decoder

Interface
REQ-001 Parameter FRAME_BYTES, default 512, is the total bytes per frame: 3 sync, 5 C&C and FRAME_BYTES-8 payload.
REQ-002 Parameter SYNC_BYTE, default 8'h7F, is the sync byte value.
REQ-003 Parameter PTT_TIMEOUT, default 1_228_800, is the number of clocks without a committed frame before PTT is forced off.
REQ-004 clock  input  1  single clock; all logic is on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 rx_byte  input  8  command-stream byte.
REQ-007 rx_valid  input  1  rx_byte is accepted on any edge where this is high.
REQ-008 frequency_HZ  output  32  tuning frequency for the Alex filter stage: tx_frequency when PTT_out=1, else rx_frequency.
REQ-009 tx_frequency  output  32  last committed Tx NCO frequency.
REQ-010 rx_frequency  output  32  last committed Rx1 frequency.
REQ-011 ATTEN  output  2  bit0 selects the 10 dB attenuator; bit1 selects the 20 dB attenuator.
REQ-012 PTT_out  output  1  MOX state.
REQ-013 locked  output  1  frame sync acquired.
REQ-014 sync_error  output  1  one-clock pulse on loss of sync.

Function
REQ-015 The state machine SHALL have the states S0, S1, S2, C0, C1, C2, C3, C4 and DATA; it advances only on accepted bytes and holds while rx_valid=0.
REQ-016 S0: SYNC_BYTE -> S1; any other byte stays in S0.
REQ-017 S1 and S2: SYNC_BYTE -> the next state (S2, then C0); any other byte -> S0.
REQ-018 C0..C4: any byte value is accepted and stored in a shadow register; C4 -> DATA.
REQ-019 DATA: a payload counter counts FRAME_BYTES-8 accepted bytes, then the state returns to S0 with the counter cleared; payload content is ignored.
REQ-020 On the third consecutive SYNC_BYTE, locked SHALL be set to 1.
REQ-021 A mismatch in S1 or S2 while locked=1 SHALL clear locked and pulse sync_error high for exactly one clock.
REQ-022 A non-sync byte in S0 while locked=1 SHALL also clear locked and pulse sync_error for one clock.
REQ-023 No sync_error SHALL be produced while locked=0 (hunting).
REQ-024 Commit SHALL occur on the edge that accepts the C4 byte, using C0..C3 from shadow and C4 direct from rx_byte; all updates from one frame are atomic.
REQ-025 On commit: PTT_out <= C0[0], for every address.
REQ-026 On commit, address = C0[7:1]:
- 0x00: ATTEN <= C3[1:0].
- 0x01: tx_frequency <= {C1,C2,C3,C4} (big-endian).
- 0x02: rx_frequency <= {C1,C2,C3,C4} (big-endian).
- Any other address: fields unchanged; PTT still updates.
REQ-027 frequency_HZ SHALL be registered; it reflects a commit or PTT change one clock after the edge that changed PTT_out or the frequency registers.
REQ-028 A frame that loses sync before C4 SHALL commit nothing; previously committed values hold.
REQ-029 The watchdog counter SHALL clear on every commit and otherwise increment, saturating at PTT_TIMEOUT.
REQ-030 On reaching PTT_TIMEOUT, PTT_out SHALL be forced to 0; the frequency, ATTEN and locked values are unaffected.
REQ-031 If a commit occurs on the same edge the timeout is reached, the commit wins and the counter clears.
REQ-032 rx_valid held low anywhere mid-frame SHALL only stall the frame; it is not an error.

Reset
REQ-033 While reset_n=0 at an edge:
- state -> S0; payload and watchdog counters -> 0; shadow registers -> 0.
- frequency_HZ, tx_frequency, rx_frequency -> 0; ATTEN -> 0; PTT_out -> 0; locked -> 0; sync_error -> 0.
REQ-034 Reset mid-frame SHALL discard the partial frame.
REQ-035 After reset, the first byte accepted on the edge after reset_n=1 is treated as an S0 input.

Verification
REQ-036 Frame 7F 7F 7F 04 00 6B 6C 00 followed by 504 payload bytes -> rx_frequency = 0x006B6C00 (7,040,000); PTT_out=0; frequency_HZ = 7,040,000 one clock after C4; locked=1.
REQ-037 Frame with C0=0x03 and C1..C4 = 00 D6 D8 00, following the REQ-036 frame -> tx_frequency = 14,080,000; PTT_out=1; frequency_HZ = 14,080,000 one clock later.
REQ-038 C0=0x00, C3=0x02 -> ATTEN=2'b10 with frequencies unchanged; then C0=0x0E (address 7) -> ATTEN and frequencies unchanged, PTT_out=0.
REQ-039 While locked, sync 7F 7F 55 -> one-clock sync_error and locked=0; a subsequent frame whose C4 is never sent -> no commit; the next full frame relocks and commits.
REQ-040 PTT_out=1 with no further frames for PTT_TIMEOUT clocks -> PTT_out=0 and frequency_HZ reverts to rx_frequency; rx_valid gaps of random length inside frames -> results identical to gap-free streams.
REQ-041 reset_n=0 asserted during C2 -> all outputs 0; a following full frame commits normally.

Source files
------------

// File: rtl/alex_cc_decoder.sv
// Alex C&C frame decoder: hunts 3-byte sync, captures five
// control bytes, commits filter/PTT/NCO fields atomically.
module alex_cc_decoder #(
  parameter int         FRAME_BYTES = 512,
  parameter logic [7:0] SYNC_BYTE   = 8'h7F,
  parameter int         PTT_TIMEOUT = 1_228_800
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] frequency_HZ,
  output logic [31:0] tx_frequency,
  output logic [31:0] rx_frequency,
  output logic [1:0]  ATTEN,
  output logic        PTT_out,
  output logic        locked,
  output logic        sync_error
);

  localparam int PAY_W = $clog2(FRAME_BYTES);
  localparam int WD_W  = $clog2(PTT_TIMEOUT + 1);

  localparam logic [PAY_W-1:0] PAY_LAST =
    PAY_W'(FRAME_BYTES - 9);
  localparam logic [WD_W-1:0]  WD_MAX =
    WD_W'(PTT_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_NEAR =
    WD_W'(PTT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S0, S1, S2, C0, C1, C2, C3, C4, DATA
  } state_t;

  state_t           state;
  logic [PAY_W-1:0] pay_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [7:0]       c0_q;
  logic [7:0]       c1_q;
  logic [7:0]       c2_q;
  logic [7:0]       c3_q;
  logic             commit;
  logic             is_sync;

  // C4 is taken straight from the bus, so commit is combinational
  always_comb begin
    commit  = rx_valid && (state == C4);
    is_sync = (rx_byte == SYNC_BYTE);
  end

  // frame FSM, field registers, watchdog and output pipeline
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S0;
      pay_cnt      <= '0;
      wd_cnt       <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      c2_q         <= '0;
      c3_q         <= '0;
      frequency_HZ <= '0;
      tx_frequency <= '0;
      rx_frequency <= '0;
      ATTEN        <= '0;
      PTT_out      <= 1'b0;
      locked       <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      sync_error   <= 1'b0;
      frequency_HZ <= PTT_out ? tx_frequency
                              : rx_frequency;

      if (commit)
        wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + 1'b1;

      // timeout drop; a commit below overrides it
      if (!commit && wd_cnt >= WD_NEAR)
        PTT_out <= 1'b0;

      if (rx_valid) begin
        unique case (state)
          S0: begin
            if (is_sync) begin
              state <= S1;
            end else if (locked) begin
              locked     <= 1'b0;
              sync_error <= 1'b1;
            end
          end
          S1, S2: begin
            if (is_sync) begin
              state <= (state == S1) ? S2 : C0;
              if (state == S2)
                locked <= 1'b1;
            end else begin
              state <= S0;
              if (locked) begin
                locked     <= 1'b0;
                sync_error <= 1'b1;
              end
            end
          end
          C0: begin
            c0_q  <= rx_byte;
            state <= C1;
          end
          C1: begin
            c1_q  <= rx_byte;
            state <= C2;
          end
          C2: begin
            c2_q  <= rx_byte;
            state <= C3;
          end
          C3: begin
            c3_q  <= rx_byte;
            state <= C4;
          end
          C4: begin
            state   <= DATA;
            PTT_out <= c0_q[0];
            unique case (1'b1)
              (c0_q[7:1] == 7'h00):
                ATTEN <= c3_q[1:0];
              (c0_q[7:1] == 7'h01):
                tx_frequency <=
                  {c1_q, c2_q, c3_q, rx_byte};
              (c0_q[7:1] == 7'h02):
                rx_frequency <=
                  {c1_q, c2_q, c3_q, rx_byte};
              default: ;
            endcase
          end
          DATA: begin
            if (pay_cnt == PAY_LAST) begin
              pay_cnt <= '0;
              state   <= S0;
            end else begin
              pay_cnt <= pay_cnt + 1'b1;
            end
          end
          default: state <= S0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alex_cc_decoder.sv
// Bench for alex_cc_decoder: byte-stream reference model
// with directed frames, random gaps and random frames.
module tb_alex_cc_decoder;

  localparam int         FB   = 64;
  localparam int         PT   = 400;
  localparam logic [7:0] SYNC = 8'h7F;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] frequency_HZ;
  logic [31:0] tx_frequency;
  logic [31:0] rx_frequency;
  logic [1:0]  ATTEN;
  logic        PTT_out;
  logic        locked;
  logic        sync_error;

  alex_cc_decoder #(
    .FRAME_BYTES(FB),
    .SYNC_BYTE  (SYNC),
    .PTT_TIMEOUT(PT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .frequency_HZ(frequency_HZ),
    .tx_frequency(tx_frequency),
    .rx_frequency(rx_frequency),
    .ATTEN       (ATTEN),
    .PTT_out     (PTT_out),
    .locked      (locked),
    .sync_error  (sync_error)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // reference model: position within frame plus field values
  int          pos;
  bit          lk;
  logic [7:0]  cb [4];
  logic [31:0] m_tx, m_rx, m_fhz;
  logic [1:0]  m_att;
  bit          m_ptt, m_serr;
  int          since;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("frequency_HZ", frequency_HZ, m_fhz);
    chk("tx_frequency", tx_frequency, m_tx);
    chk("rx_frequency", rx_frequency, m_rx);
    chk("ATTEN", 32'(ATTEN), 32'(m_att));
    chk("PTT_out", 32'(PTT_out), 32'(m_ptt));
    chk("locked", 32'(locked), 32'(lk));
    chk("sync_error", 32'(sync_error), 32'(m_serr));
  endtask

  task automatic model_reset();
    pos = 0; lk = 0; since = 0;
    m_tx = '0; m_rx = '0; m_fhz = '0;
    m_att = '0; m_ptt = 0; m_serr = 0;
    for (int i = 0; i < 4; i++) cb[i] = '0;
  endtask

  // one clock edge with optional byte, model update, full check
  task automatic step(input bit v, input logic [7:0] b);
    logic [31:0] fnew;
    bit          cm;
    rx_valid = v;
    rx_byte  = b;
    @(posedge clock);
    #1;
    fnew   = m_ptt ? m_tx : m_rx;
    m_serr = 0;
    cm     = 0;
    if (v) begin
      if (pos < 3) begin
        if (b == SYNC) begin
          pos++;
          if (pos == 3) lk = 1;
        end else begin
          if (lk) begin
            m_serr = 1;
            lk = 0;
          end
          pos = 0;
        end
      end else if (pos < 7) begin
        cb[pos-3] = b;
        pos++;
      end else begin
        if (pos == 7) begin
          cm    = 1;
          m_ptt = cb[0][0];
          case (cb[0][7:1])
            7'd0: m_att = cb[3][1:0];
            7'd1: m_tx = {cb[1], cb[2], cb[3], b};
            7'd2: m_rx = {cb[1], cb[2], cb[3], b};
            default: ;
          endcase
        end
        pos++;
        if (pos == FB) pos = 0;
      end
    end
    if (cm) begin
      since = 0;
    end else begin
      if (since < PT) since++;
      if (since == PT) m_ptt = 0;
    end
    m_fhz = fnew;
    check_all();
  endtask

  task automatic do_reset(input int n);
    reset_n  = 0;
    rx_valid = 1;
    rx_byte  = SYNC;
    repeat (n) @(posedge clock);
    #1;
    model_reset();
    check_all();
    reset_n  = 1;
    rx_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 8'($urandom));
  endtask

  // sends the first 'upto' bytes of a frame, with random gaps
  task automatic frame(input logic [7:0] c0, c1, c2, c3, c4,
                       input int maxgap, input int upto);
    logic [7:0] q[$];
    q = {SYNC, SYNC, SYNC, c0, c1, c2, c3, c4};
    while (q.size() < FB) q.push_back(8'($urandom));
    for (int i = 0; i < upto; i++) begin
      idle($urandom_range(0, maxgap));
      step(1, q[i]);
    end
  endtask

  initial begin
    model_reset();
    do_reset(3);

    frame(8'h04, 8'h00, 8'h6B, 8'h6C, 8'h00, 0, FB);
    chk("f1 rx", rx_frequency, 32'd7_040_000);
    chk("f1 ptt", 32'(PTT_out), 32'd0);
    chk("f1 fhz", frequency_HZ, 32'd7_040_000);
    chk("f1 lock", 32'(locked), 32'd1);

    frame(8'h03, 8'h00, 8'hD6, 8'hD8, 8'h00, 0, FB);
    chk("f2 tx", tx_frequency, 32'd14_080_000);
    chk("f2 ptt", 32'(PTT_out), 32'd1);
    chk("f2 fhz", frequency_HZ, 32'd14_080_000);

    frame(8'h00, 8'h11, 8'h22, 8'h02, 8'h33, 0, FB);
    chk("f3 att", 32'(ATTEN), 32'd2);
    chk("f3 rx", rx_frequency, 32'd7_040_000);
    chk("f3 tx", tx_frequency, 32'd14_080_000);

    frame(8'h0E, 8'h12, 8'h34, 8'h01, 8'h56, 1, FB);
    chk("f4 att", 32'(ATTEN), 32'd2);
    chk("f4 ptt", 32'(PTT_out), 32'd0);
    chk("f4 tx", tx_frequency, 32'd14_080_000);

    step(1, SYNC);
    step(1, SYNC);
    step(1, 8'h55);
    chk("loss serr", 32'(sync_error), 32'd1);
    chk("loss lock", 32'(locked), 32'd0);
    step(0, 8'h00);
    chk("serr pulse", 32'(sync_error), 32'd0);

    frame(8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1, 5);
    idle(10);
    chk("trunc rx", rx_frequency, 32'd7_040_000);
    chk("trunc ptt", 32'(PTT_out), 32'd0);
    do_reset(1);
    chk("rst fhz", frequency_HZ, 32'd0);

    frame(8'h04, 8'h00, 8'h6B, 8'h6C, 8'h00, 2, FB);
    chk("relock rx", rx_frequency, 32'd7_040_000);
    chk("relock", 32'(locked), 32'd1);

    frame(8'h03, 8'h00, 8'hD6, 8'hD8, 8'h00, 2, FB);
    idle(PT + 5);
    chk("wd ptt", 32'(PTT_out), 32'd0);
    chk("wd fhz", frequency_HZ, 32'd7_040_000);
    chk("wd lock", 32'(locked), 32'd1);

    // next C4 lands exactly on the timeout edge
    frame(8'h03, 8'h00, 8'hD6, 8'hD8, 8'h00, 0, FB);
    idle(PT - FB);
    frame(8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 0, FB);
    chk("tie ptt", 32'(PTT_out), 32'd1);
    chk("tie tx", tx_frequency, 32'h0011_2233);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] c0;
      c0 = 8'($urandom);
      if (n % 4 != 3) c0[7:1] = 7'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        int j;
        j = $urandom_range(1, 3);
        for (int k = 0; k < j; k++)
          step(1, 8'($urandom_range(0, 8'h7E)));
      end
      frame(c0, 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 3, FB);
    end
    idle(PT + 2);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
